// File: rtl/div_iter_pkg.sv
//==============================================================================
// Module      : div_iter_pkg
// Description : State encodings and handshake levels shared by the divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package div_iter_pkg;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/div_iter_lzc_w.sv
//==============================================================================
// Module      : lzc_w
// Description : Combinational leading-zero counter; all-zero input yields WIDTH.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lzc_w #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    logic w_found;

    always_comb begin
        count   = CNT_W'(WIDTH);
        w_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_found && data[i]) begin
                count   = CNT_W'(WIDTH - 1 - i);
                w_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_iter.sv
//==============================================================================
// Module      : div_iter
// Description : Iterative radix-2 restoring divider with early-out, divide-by-
//               zero flag and annul abort.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EARLY_OUT = 1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_by_zero_o
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [CNT_W-1:0] w_lz;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quot_fix;

    // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    generate
        if (EARLY_OUT == 1) begin : g_lzc
            lzc_w #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_lzc (
                .data  (w_abs1),
                .count (w_lz)
            );
        end else begin : g_no_lzc
            assign w_lz = '0;
        end
    endgenerate

    // Partial remainder stays below the divisor, so bit WIDTH of the
    // difference is a clean borrow indicator.
    assign w_shifted   = {r_rem, r_dividend[WIDTH-1]};
    assign w_diff      = w_shifted - {1'b0, r_divisor};
    assign w_qbit      = ~w_diff[WIDTH];
    assign w_rem_next  = w_qbit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_qbit};
    assign w_quot_fix  = r_neg_q ? -w_quot_next : w_quot_next;
    assign w_rem_fix   = r_neg_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= DivFree;
            r_cnt         <= '0;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_quot        <= '0;
            r_rem         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            result_o      <= '0;
            ready_o       <= DivResultNotReady;
            div_by_zero_o <= 1'b0;
        end else if (annul_i) begin
            r_state       <= DivFree;
            result_o      <= '0;
            ready_o       <= DivResultNotReady;
            div_by_zero_o <= 1'b0;
        end else begin
            case (r_state)
                DivFree: begin
                    if (start_i == DivStart) begin
                        r_neg_q    <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        r_neg_r    <= signed_div_i & opdata1_i[WIDTH-1];
                        r_divisor  <= w_abs2;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_cnt      <= w_lz;
                        r_dividend <= w_abs1 << w_lz;
                        if (opdata2_i == '0) begin
                            r_state <= DivByZero;
                        end else if ((EARLY_OUT == 1) && (w_abs1 == '0)) begin
                            r_state  <= DivEnd;
                            result_o <= '0;
                            ready_o  <= DivResultReady;
                        end else begin
                            r_state <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    r_state       <= DivEnd;
                    result_o      <= '0;
                    ready_o       <= DivResultReady;
                    div_by_zero_o <= 1'b1;
                end
                DivOn: begin
                    r_rem      <= w_rem_next;
                    r_quot     <= w_quot_next;
                    r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state  <= DivEnd;
                        result_o <= {w_rem_fix, w_quot_fix};
                        ready_o  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        r_state       <= DivFree;
                        result_o      <= '0;
                        ready_o       <= DivResultNotReady;
                        div_by_zero_o <= 1'b0;
                    end
                end
                default: r_state <= DivFree;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
//==============================================================================
// Module      : tb_div_iter
// Description : Bench for div_iter; runs EARLY_OUT=0 and EARLY_OUT=1 side by side.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic        start;
    logic        annul;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  rdy;
    logic [1:0]  dbz;
    logic [63:0] res [2];

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level model: 0 idle, 1 computing, 2 result held
    int          m_phase [2];
    int          m_left  [2];
    logic [63:0] m_res   [2];
    logic [63:0] m_pend  [2];
    logic        m_dbz   [2];
    logic        m_pdbz  [2];

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32), .EARLY_OUT(0)) u_eo0 (
        .clk           (clk),
        .rst           (rst),
        .signed_div_i  (signed_div),
        .opdata1_i     (op1),
        .opdata2_i     (op2),
        .start_i       (start),
        .annul_i       (annul),
        .result_o      (res[0]),
        .ready_o       (rdy[0]),
        .div_by_zero_o (dbz[0])
    );

    div_iter #(.WIDTH(32), .EARLY_OUT(1)) u_eo1 (
        .clk           (clk),
        .rst           (rst),
        .signed_div_i  (signed_div),
        .opdata1_i     (op1),
        .opdata2_i     (op2),
        .start_i       (start),
        .annul_i       (annul),
        .result_o      (res[1]),
        .ready_o       (rdy[1]),
        .div_by_zero_o (dbz[1])
    );

    function automatic logic [63:0] exp_result(input logic sg, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input int eo, input logic sg, input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] m;
        int n;
        if (b == 32'd0) return 2;
        if (eo == 0) return 33;
        m = (sg && a[31]) ? -a : a;
        if (m == 32'd0) return 1;
        n = 0;
        while (m != 32'd0) begin
            m = m >> 1;
            n++;
        end
        return 1 + n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] <= 0;
                m_left[k]  <= 0;
                m_res[k]   <= 64'd0;
                m_pend[k]  <= 64'd0;
                m_dbz[k]   <= 1'b0;
                m_pdbz[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (annul) begin
                    m_phase[k] <= 0;
                    m_res[k]   <= 64'd0;
                    m_dbz[k]   <= 1'b0;
                end else if (m_phase[k] == 0) begin
                    if (start) begin
                        if (exp_lat(k, signed_div, op1, op2) == 1) begin
                            m_phase[k] <= 2;
                            m_res[k]   <= exp_result(signed_div, op1, op2);
                            m_dbz[k]   <= (op2 == 32'd0);
                        end else begin
                            m_phase[k] <= 1;
                            m_left[k]  <= exp_lat(k, signed_div, op1, op2) - 1;
                            m_pend[k]  <= exp_result(signed_div, op1, op2);
                            m_pdbz[k]  <= (op2 == 32'd0);
                        end
                    end
                end else if (m_phase[k] == 1) begin
                    m_left[k] <= m_left[k] - 1;
                    if (m_left[k] == 1) begin
                        m_phase[k] <= 2;
                        m_res[k]   <= m_pend[k];
                        m_dbz[k]   <= m_pdbz[k];
                    end
                end else if (!start) begin
                    m_phase[k] <= 0;
                    m_res[k]   <= 64'd0;
                    m_dbz[k]   <= 1'b0;
                end
            end
        end
    end

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (rdy[k] !== (m_phase[k] == 2) || res[k] !== m_res[k] || dbz[k] !== m_dbz[k]) begin
                    miscompares++;
                    $display("FAIL cycle_eo%0d t=%0t: got ready=%b result=%h dbz=%b, required ready=%b result=%h dbz=%b",
                             k, $time, rdy[k], res[k], dbz[k], (m_phase[k] == 2), m_res[k], m_dbz[k]);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    // Called 1 time unit after a rising edge; accepting edge is edge 1.
    task automatic run(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input int l0, input int l1, input logic [63:0] want, input logic want_dbz);
        int s0, s1;
        s0 = 0;
        s1 = 0;
        signed_div = sg;
        op1 = a;
        op2 = b;
        start = 1'b1;
        for (int n = 1; n <= 40 && (s0 == 0 || s1 == 0); n++) begin
            @(posedge clk);
            #1;
            if (rdy[0] && s0 == 0) s0 = n;
            if (rdy[1] && s1 == 0) s1 = n;
        end
        op1 = ~a;
        op2 = b ^ 32'h5;
        @(posedge clk);
        #1;
        chk("latency_eo0", 64'(s0), 64'(l0));
        chk("latency_eo1", 64'(s1), 64'(l1));
        chk("result_eo0", res[0], want);
        chk("result_eo1", res[1], want);
        chk("dbz_flags", {62'd0, dbz}, {62'd0, want_dbz, want_dbz});
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_clears", {rdy, dbz, res[0][31:0]}, 36'd0);
    endtask

    initial begin
        logic seen;
        rst = 1'b0;
        start = 1'b0;
        annul = 1'b0;
        signed_div = 1'b0;
        op1 = 32'd0;
        op2 = 32'd0;
        fork
            compare_loop();
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {62'd0, rdy}, 64'd0);
        chk("reset_res0", res[0], 64'd0);
        chk("reset_res1", res[1], 64'd0);
        chk("reset_dbz", {62'd0, dbz}, 64'd0);
        rst = 1'b1;

        run(1'b0, 32'd100, 32'd7, 33, 8, {32'd2, 32'd14}, 1'b0);
        run(1'b0, 32'd5, 32'd3, 33, 4, {32'd2, 32'd1}, 1'b0);
        run(1'b0, 32'd0, 32'd9, 33, 1, 64'd0, 1'b0);
        run(1'b0, 32'd1234, 32'd0, 2, 2, 64'd0, 1'b1);
        run(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 4, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 33, {32'd0, 32'h8000_0000}, 1'b0);
        run(1'b0, 32'hFFFF_FFFF, 32'h10, 33, 33, {32'hF, 32'h0FFF_FFFF}, 1'b0);
        run(1'b1, 32'd7, 32'hFFFF_FFFE, 33, 4, {32'd1, 32'hFFFF_FFFD}, 1'b0);

        // Annul partway through the long computation
        signed_div = 1'b0;
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | rdy[0];
        end
        annul = 1'b1;
        @(posedge clk);
        #1;
        seen = seen | rdy[0];
        chk("annul_clears", {rdy, dbz}, 64'd0);
        chk("annul_res1", res[1], 64'd0);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_no_ready", {63'd0, seen}, 64'd0);

        run(1'b0, 32'd50, 32'd5, 33, 7, {32'd0, 32'd10}, 1'b0);

        // Asynchronous reset while eo1 holds a result and eo0 is still iterating
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_flags", {60'd0, rdy, dbz}, 64'd0);
        chk("rst_res0", res[0], 64'd0);
        chk("rst_res1", res[1], 64'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        run(1'b1, 32'hFFFF_FF9C, 32'd7, 33, 8, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
